log2_unit: RTL and testbench

- Inverse of the GELU exponential unit: computes y = log2(x) for an unsigned Q48.16 operand and returns Q10.22.
- Uses the same 8-segment piecewise-linear slope/intercept scheme as the exponential path. Segment coefficients K and B come from an external synchronous coefficient ROM over a registered index/return interface.
- Sits in the GELU/softmax datapath wherever a log-domain value is needed, between the 64-bit exp accumulator and the Q10.22 arithmetic.
- Iterative and multi-cycle, with valid/ready handshakes on input and output.

---
 rtl/log2_unit.sv | 172 +++++++++++++++++
 tb/tb_log2_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/log2_unit.sv
// Iterative log2 of an unsigned Q48.16 operand, producing a signed Q10.22 result
// from an 8-segment piecewise-linear mantissa fit. Define LOG2_UNIT_LN_OUT_EN for natural-log output.
module log2_unit #(
  parameter int WIDTH       = 32,
  parameter int Q_IN        = 16,
  parameter int Q_OUT       = 22,
  parameter int LUT_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WIDTH-1:0]   in_x,
  output logic [2:0]           lut_index,
  input  logic [WIDTH-1:0]     lut_k,
  input  logic [WIDTH-1:0]     lut_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_y,
  output logic                 out_zero_err
);

  // state | meaning
  // IDLE  | waiting for an operand, in_ready high
  // NORM  | find leading one, extract mantissa fraction and segment index
  // LUT   | hold lut_index until the ROM coefficients are valid
  // CALC  | y = (p - Q_IN) + K*f + B
  // LN    | optional: scale log2 by ln(2)
  // OUT   | present result until the consumer takes it

  localparam int XW = 2 * WIDTH;
  localparam int PW = $clog2(XW);
  localparam logic [WIDTH-1:0] ZERO_Y = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    NORM,
    LUT,
    CALC,
    OUT
`ifdef LOG2_UNIT_LN_OUT_EN
    , LN
`endif
  } state_t;

  state_t state, state_next;

  logic [XW-1:0]           x_reg;
  logic [PW-1:0]           p_reg;
  logic [Q_OUT-1:0]        f_reg;
  logic signed [WIDTH-1:0] k_reg;
  logic signed [WIDTH-1:0] b_reg;
  logic [1:0]              wait_cnt;

  logic [PW-1:0]           lead;
  logic [Q_OUT-1:0]        f_next;
  logic                    x_zero;
  logic                    lut_done;
  logic signed [WIDTH-1:0] f_ext;
  logic signed [WIDTH-1:0] mant;
  logic signed [WIDTH-1:0] int_part;
  logic signed [WIDTH-1:0] y_calc;

  // Leading-one position; the highest set bit wins because it is visited last.
  always_comb begin
    lead = '0;
    for (int i = 0; i < XW; i++) begin
      if (x_reg[i]) lead = PW'(i);
    end
  end

  always_comb begin
    f_next = Q_OUT'((x_reg << (PW'(XW-1) - lead)) >> (XW-1-Q_OUT));
  end

  assign x_zero   = (x_reg == '0);
  assign lut_done = (wait_cnt == 2'(LUT_LATENCY-1));

  always_comb begin
    f_ext    = {{(WIDTH-Q_OUT){1'b0}}, f_reg};
    mant     = WIDTH'((XW'(k_reg) * XW'(f_ext)) >>> Q_OUT) + b_reg;
    int_part = WIDTH'(p_reg) - WIDTH'(Q_IN);
    y_calc   = (int_part <<< Q_OUT) + mant;
  end

`ifdef LOG2_UNIT_LN_OUT_EN
  localparam logic signed [WIDTH-1:0] LN2_Q = WIDTH'(2907270);
  logic signed [WIDTH-1:0] ln_calc;
  always_comb begin
    ln_calc = WIDTH'((XW'($signed(out_y)) * XW'(LN2_Q)) >>> Q_OUT);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = NORM;
      NORM: state_next = x_zero ? OUT : LUT;
      LUT:  if (lut_done) state_next = CALC;
`ifdef LOG2_UNIT_LN_OUT_EN
      CALC: state_next = LN;
      LN:   state_next = OUT;
`else
      CALC: state_next = OUT;
`endif
      OUT:  if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      OUT:     out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath registers; a zero operand skips the ROM so lut_index keeps its value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg        <= '0;
      p_reg        <= '0;
      f_reg        <= '0;
      k_reg        <= '0;
      b_reg        <= '0;
      wait_cnt     <= '0;
      lut_index    <= '0;
      out_y        <= '0;
      out_zero_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) x_reg <= in_x;
        NORM: begin
          if (x_zero) begin
            out_y        <= ZERO_Y;
            out_zero_err <= 1'b1;
          end else begin
            p_reg     <= lead;
            f_reg     <= f_next;
            lut_index <= f_next[Q_OUT-1 -: 3];
            wait_cnt  <= '0;
          end
        end
        LUT: begin
          if (lut_done) begin
            k_reg <= $signed(lut_k);
            b_reg <= $signed(lut_b);
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        CALC: begin
          out_y        <= y_calc;
          out_zero_err <= 1'b0;
        end
`ifdef LOG2_UNIT_LN_OUT_EN
        LN: out_y <= ln_calc;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_log2_unit.sv
// Self-checking bench for log2_unit: directed vectors with an identity ROM,
// hold/reset sequences, then random operands against an arithmetic reference model.
module tb_log2_unit;

  localparam int LUT_LATENCY = 1;
`ifdef LOG2_UNIT_LN_OUT_EN
  localparam int LAT_NZ = LUT_LATENCY + 4;
`else
  localparam int LAT_NZ = LUT_LATENCY + 3;
`endif
  localparam int LAT_Z = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_x;
  logic [2:0]  lut_index;
  logic [31:0] lut_k;
  logic [31:0] lut_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y;
  logic        out_zero_err;

  logic [31:0] rom_k [8];
  logic [31:0] rom_b [8];

  int checks = 0;
  int errors = 0;
  logic [2:0] model_idx = 3'd0;

  always #5 clk = ~clk;

  assign lut_k = rom_k[lut_index];
  assign lut_b = rom_b[lut_index];

  log2_unit #(.WIDTH(32), .Q_IN(16), .Q_OUT(22), .LUT_LATENCY(LUT_LATENCY)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .lut_index(lut_index), .lut_k(lut_k), .lut_b(lut_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_zero_err(out_zero_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ln_adj(input logic [31:0] y);
`ifdef LOG2_UNIT_LN_OUT_EN
    longint t;
    t = longint'($signed(y)) * 64'sd2907270;
    t = t >>> 22;
    return t[31:0];
`else
    return y;
`endif
  endfunction

  // y = floor(log2 x) - 16 + K*f + B, with f the fraction below the leading one.
  function automatic void model(input logic [63:0] x, output logic [31:0] y,
                                output logic err, output logic [2:0] idx);
    int          p;
    logic [63:0] rem;
    longint      f, prod, yl;
    if (x == 64'd0) begin
      y = 32'h8000_0000;
      err = 1'b1;
      idx = model_idx;
      return;
    end
    p = 0;
    while ((x >> p) > 64'd1) p++;
    rem = x - (64'd1 << p);
    if (p >= 22) f = longint'(rem >> (p - 22));
    else         f = longint'(rem << (22 - p));
    idx = 3'(f / 524288);
    prod = longint'($signed(rom_k[idx])) * f;
    yl = longint'(p - 16) * 4194304 + (prod >>> 22) + longint'($signed(rom_b[idx]));
    y = ln_adj(yl[31:0]);
    err = 1'b0;
    model_idx = idx;
  endfunction

  task automatic run_op(input logic [63:0] x, output logic [31:0] y, output logic err,
                        output logic [2:0] idx, output int lat);
    int budget;
    @(negedge clk);
    in_x = x;
    in_valid = 1'b1;
    budget = 0;
    while (!in_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1 lat++;
    end
    y = out_y;
    err = out_zero_err;
    idx = lut_index;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  typedef struct {
    logic [63:0] x;
    logic [31:0] y;
    logic        err;
    logic [2:0]  idx;
    int          lat;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [31:0] y, ey, hy;
    logic        err, eerr;
    logic [2:0]  idx, eidx;
    int          lat, budget;
    logic [63:0] xa, xb, r;

    vecs[0] = '{64'h0000_0000_0001_0000, 32'h0000_0000, 1'b0, 3'd0, LAT_NZ};
    vecs[1] = '{64'h0000_0000_0001_8000, 32'h0020_0000, 1'b0, 3'd4, LAT_NZ};
    vecs[2] = '{64'h0000_0000_0000_0000, 32'h8000_0000, 1'b1, 3'd4, LAT_Z};
    vecs[3] = '{64'h0000_0000_0000_0001, 32'hFC00_0000, 1'b0, 3'd0, LAT_NZ};
    vecs[4] = '{64'h0002_0000_0000_0000, 32'h0840_0000, 1'b0, 3'd0, LAT_NZ};
    vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 32'h0BFF_FFFF, 1'b0, 3'd7, LAT_NZ};

    for (int i = 0; i < 8; i++) begin
      rom_k[i] = 32'h0040_0000;
      rom_b[i] = 32'h0;
    end

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_x = '0;
    repeat (2) @(negedge clk);
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset out_y", 64'(out_y), 64'd0);
    check("reset out_zero_err", 64'(out_zero_err), 64'd0);
    check("reset lut_index", 64'(lut_index), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].x, y, err, idx, lat);
      ey = vecs[i].err ? vecs[i].y : ln_adj(vecs[i].y);
      check($sformatf("vec%0d y", i), 64'(y), 64'(ey));
      check($sformatf("vec%0d err", i), 64'(err), 64'(vecs[i].err));
      check($sformatf("vec%0d idx", i), 64'(idx), 64'(vecs[i].idx));
      check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
    end
    model_idx = 3'd7;

    // Output held under back-pressure; a waiting operand is taken only after the handshake.
    xa = 64'h0000_0003_0000_0000;
    xb = 64'h0000_0000_0000_5000;
    @(negedge clk);
    in_x = xa;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    budget = 0;
    while (!out_valid && budget < 50) begin
      @(posedge clk);
      #1 budget++;
    end
    hy = out_y;
    model(xa, ey, eerr, eidx);
    check("hold first y", 64'(hy), 64'(ey));
    in_x = xb;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold out_valid", 64'(out_valid), 64'd1);
      check("hold out_y", 64'(out_y), 64'(hy));
      check("hold in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("after handshake out_valid", 64'(out_valid), 64'd0);
    check("after handshake in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("next accepted", 64'(in_ready), 64'd0);
    budget = 1;
    while (!out_valid && budget < 50) begin
      @(posedge clk);
      #1 budget++;
    end
    model(xb, ey, eerr, eidx);
    check("second y", 64'(out_y), 64'(ey));
    check("second latency", 64'(budget), 64'(LAT_NZ));
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;

    // Reset while the ROM is being read discards the operation.
    @(negedge clk);
    in_x = 64'h0000_1234_5678_9ABC;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid reset out_valid", 64'(out_valid), 64'd0);
    check("mid reset in_ready", 64'(in_ready), 64'd1);
    model_idx = 3'd0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(64'h0000_0000_0002_C000, y, err, idx, lat);
    model(64'h0000_0000_0002_C000, ey, eerr, eidx);
    check("post reset y", 64'(y), 64'(ey));
    check("post reset latency", 64'(lat), 64'(LAT_NZ));

    for (int i = 0; i < 8; i++) begin
      rom_k[i] = 32'($urandom_range(32'h0020_0000, 32'h0060_0000));
      rom_b[i] = 32'($urandom_range(0, 32'h0010_0000)) - 32'h0008_0000;
    end
    for (int n = 0; n < 60; n++) begin
      r = {$urandom, $urandom};
      r = r >> $urandom_range(0, 63);
      if ($urandom_range(0, 9) == 0) r = 64'd0;
      model(r, ey, eerr, eidx);
      run_op(r, y, err, idx, lat);
      check($sformatf("rand%0d y x=%h", n, r), 64'(y), 64'(ey));
      check($sformatf("rand%0d err", n), 64'(err), 64'(eerr));
      check($sformatf("rand%0d idx", n), 64'(idx), 64'(eidx));
      check($sformatf("rand%0d latency", n), 64'(lat), 64'(eerr ? LAT_Z : LAT_NZ));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
